// File: rtl/pdm_decimator.sv
// 2nd-order CIC decimator (M=1) turning a 1-bit PDM stream into unsigned PCM samples with a valid/ready output register.
// Define PDM_DECIM_OVERRUN_EN to get a sticky overrun flag; otherwise overrun is tied low.
module pdm_decimator #(
   parameter int DECIM = 32,
   parameter int OUT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pdm_in,
   input  logic             pdm_en,
   output logic [OUT_W-1:0] sample_out,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun
);

   localparam int LG    = $clog2(DECIM);
   localparam int W     = 2 * LG + 1;
   localparam int SHIFT = 2 * LG - OUT_W;

   // Handshake: a sample is consumed on any cycle with sample_valid=1 and
   // sample_ready=1. sample_valid is purely registered, and a newly loaded
   // sample always wins over holding or clearing the current one.

   logic [LG-1:0]    phase;
   logic [W-1:0]     i1, i2, i1_next, i2_next;
   logic [W-1:0]     i2_cap, i2_prev, c1_prev;
   logic [W-1:0]     c1, c2, scaled;
   logic             cap_pend;
   logic [1:0]       trans_cnt;
   logic             load;
   logic [OUT_W-1:0] new_sample;

   assign i1_next = i1 + {{(W-1){1'b0}}, pdm_in};
   assign i2_next = i2 + i1_next;

   // Integrators run on enabled bits; the last bit of a window snapshots i2
   // so the comb stage can work on it during the following cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase     <= '0;
         i1        <= '0;
         i2        <= '0;
         i2_cap    <= '0;
         cap_pend  <= 1'b0;
         i2_prev   <= '0;
         c1_prev   <= '0;
         trans_cnt <= '0;
      end else begin
         cap_pend <= 1'b0;
         if (pdm_en) begin
            i1    <= i1_next;
            i2    <= i2_next;
            phase <= phase + 1'b1;
            if (&phase) begin
               i2_cap   <= i2_next;
               cap_pend <= 1'b1;
            end
         end
         if (cap_pend) begin
            i2_prev <= i2_cap;
            c1_prev <= c1;
            if (trans_cnt != 2'd2) trans_cnt <= trans_cnt + 2'd1;
         end
      end
   end

   assign c1     = i2_cap - i2_prev;
   assign c2     = c1 - c1_prev;
   assign scaled = c2 >> SHIFT;

   always_comb begin
      new_sample = scaled[OUT_W-1:0];
      if (|scaled[W-1:OUT_W]) new_sample = '1;
   end

   // The first two comb outputs after reset are startup transients.
   assign load = cap_pend && (trans_cnt == 2'd2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else if (load) begin
         sample_out   <= new_sample;
         sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

`ifdef PDM_DECIM_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  overrun_q <= 1'b0;
      else if (load && sample_valid && !sample_ready) overrun_q <= 1'b1;
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: a triangular-kernel window model (the CIC2 impulse response) predicts every sample.
module tb_pdm_decimator;

   localparam int DECIM = 32;
   localparam int OUT_W = 5;
   localparam int LG    = $clog2(DECIM);
   localparam int SHIFT = 2 * LG - OUT_W;
`ifdef PDM_DECIM_OVERRUN_EN
   localparam logic OVR_EN = 1'b1;
`else
   localparam logic OVR_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             reset, pdm_in, pdm_en, sample_ready;
   logic [OUT_W-1:0] sample_out;
   logic             sample_valid, overrun;

   always #5 clk = ~clk;

   pdm_decimator #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
      .clk(clk), .reset(reset), .pdm_in(pdm_in), .pdm_en(pdm_en),
      .sample_out(sample_out), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .overrun(overrun)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- reference model / scoreboard ----------------
   bit               hist[$];
   logic [OUT_W-1:0] exp_q[$];
   int               n_en, edges;
   logic             pend, exp_valid, exp_ovr;
   logic [OUT_W-1:0] exp_out;

   // A CIC2 output is the last 2*DECIM input bits weighted by a triangle:
   // newest bit weight 1 rising to DECIM, then DECIM-1 falling to 0.
   function automatic logic [OUT_W-1:0] window_sample();
      int acc = 0;
      for (int d = 0; d < 2 * DECIM; d++) begin
         int wgt = (d < DECIM) ? d + 1 : 2 * DECIM - 1 - d;
         if (hist[hist.size() - 1 - d]) acc += wgt;
      end
      acc = acc >> SHIFT;
      if (acc >= (1 << OUT_W)) acc = (1 << OUT_W) - 1;
      return acc[OUT_W-1:0];
   endfunction

   task automatic model_reset();
      hist.delete();
      exp_q.delete();
      n_en = 0; edges = 0; pend = 1'b0;
      exp_valid = 1'b0; exp_ovr = 1'b0; exp_out = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input logic b, input logic en, input logic rdy);
      pdm_in = b; pdm_en = en; sample_ready = rdy;
      @(posedge clk);
      edges++;
      if (pend) begin
         pend = 1'b0;
         if (exp_valid && !rdy) exp_ovr = OVR_EN;
         exp_out   = exp_q.pop_front();
         exp_valid = 1'b1;
      end else if (exp_valid && rdy) begin
         exp_valid = 1'b0;
      end
      if (en) begin
         hist.push_back(b);
         if (hist.size() > 2 * DECIM) void'(hist.pop_front());
         n_en++;
         if ((n_en % DECIM) == 0 && (n_en / DECIM) >= 3) begin
            exp_q.push_back(window_sample());
            pend = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; pdm_in = 1'b0; pdm_en = 1'b0; sample_ready = 1'b0;
      #3 reset = 1'b0;
      #1;
      n_checks++;
      if (sample_out !== '0) $display("FAIL reset_out got %0d want 0", sample_out); else n_pass++;
      n_checks++;
      if (sample_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", sample_valid); else n_pass++;
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_ones_latency();
      for (int e = 1; e <= 100; e++) begin
         tick(1'b1, 1'b1, 1'b1);
         n_checks++;
         if (sample_valid !== exp_valid) $display("FAIL ones_valid edge %0d got %b want %b", edges, sample_valid, exp_valid); else n_pass++;
         if (edges == 96) begin
            n_checks++;
            if (sample_valid !== 1'b0) $display("FAIL ones_early edge 96 got %b want 0", sample_valid); else n_pass++;
         end
         if (edges == 97) begin
            n_checks++;
            if (sample_valid !== 1'b1 || sample_out !== 5'd31)
               $display("FAIL ones_first edge 97 got v=%b d=%0d want v=1 d=31", sample_valid, sample_out);
            else n_pass++;
         end
      end
   endtask

   task automatic test_zeros();
      do_reset();
      for (int e = 1; e <= 200; e++) begin
         tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         n_checks++;
         if (sample_valid !== exp_valid) $display("FAIL zeros_valid edge %0d got %b want %b", edges, sample_valid, exp_valid); else n_pass++;
         if (exp_valid) begin
            n_checks++;
            if (sample_out !== '0) $display("FAIL zeros_out edge %0d got %0d want 0", edges, sample_out); else n_pass++;
         end
      end
   endtask

   task automatic test_alternating();
      do_reset();
      for (int e = 0; e < 300; e++) begin
         tick((e % 2) == 0, 1'b1, 1'b1);
         n_checks++;
         if (sample_valid !== exp_valid) $display("FAIL alt_valid edge %0d got %b want %b", edges, sample_valid, exp_valid); else n_pass++;
         if (exp_valid) begin
            n_checks++;
            if (sample_out !== 5'd16) $display("FAIL alt_out edge %0d got %0d want 16", edges, sample_out); else n_pass++;
         end
      end
   endtask

   task automatic test_sparse_enable();
      int first = -1, second = -1;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic en = (i % 4) == 0;
         tick(en ? 1'b1 : 1'($urandom_range(0, 1)), en, 1'b1);
         n_checks++;
         if (sample_valid !== exp_valid) $display("FAIL sparse_valid edge %0d got %b want %b", edges, sample_valid, exp_valid); else n_pass++;
         if (sample_valid === 1'b1) begin
            n_checks++;
            if (sample_out !== 5'd31) $display("FAIL sparse_out edge %0d got %0d want 31", edges, sample_out); else n_pass++;
            if (first < 0) first = edges;
            else if (second < 0) second = edges;
         end
      end
      n_checks++;
      if (first != 382) $display("FAIL sparse_first got edge %0d want 382", first); else n_pass++;
      n_checks++;
      if (second - first != 128) $display("FAIL sparse_period got %0d want 128", second - first); else n_pass++;
   endtask

   task automatic test_overrun();
      do_reset();
      for (int e = 1; e <= 130; e++) begin
         tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
         n_checks++;
         if (overrun !== exp_ovr) $display("FAIL ovr_flag edge %0d got %b want %b", edges, overrun, exp_ovr); else n_pass++;
      end
      n_checks++;
      if (sample_valid !== 1'b1 || sample_out !== exp_out)
         $display("FAIL ovr_second got v=%b d=%0d want v=1 d=%0d", sample_valid, sample_out, exp_out);
      else n_pass++;
      n_checks++;
      if (overrun !== OVR_EN) $display("FAIL ovr_final got %b want %b", overrun, OVR_EN); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [OUT_W-1:0] first_val;
      do_reset();
      for (int e = 1; e <= 128; e++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      first_val = exp_out;
      n_checks++;
      if (sample_valid !== 1'b1 || sample_out !== first_val)
         $display("FAIL b2b_hold got v=%b d=%0d want v=1 d=%0d", sample_valid, sample_out, first_val);
      else n_pass++;
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      n_checks++;
      if (sample_valid !== 1'b1 || sample_out !== exp_out)
         $display("FAIL b2b_new got v=%b d=%0d want v=1 d=%0d", sample_valid, sample_out, exp_out);
      else n_pass++;
      n_checks++;
      if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int e = 1; e <= 3000; e++) begin
         tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
         n_checks++;
         if (sample_valid !== exp_valid || overrun !== exp_ovr)
            $display("FAIL rand_ctrl edge %0d got v=%b o=%b want v=%b o=%b", edges, sample_valid, overrun, exp_valid, exp_ovr);
         else n_pass++;
         if (exp_valid) begin
            n_checks++;
            if (sample_out !== exp_out) $display("FAIL rand_out edge %0d got %0d want %0d", edges, sample_out, exp_out); else n_pass++;
         end
      end
   endtask

   task automatic test_midreset();
      do_reset();
      while (n_en < 113) tick(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (sample_valid !== 1'b1) $display("FAIL mid_pre got v=%b want 1", sample_valid); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (sample_out !== '0 || sample_valid !== 1'b0 || overrun !== 1'b0)
         $display("FAIL mid_clear got d=%0d v=%b o=%b want 0 0 0", sample_out, sample_valid, overrun);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      for (int e = 1; e <= 100; e++) begin
         tick(1'b1, 1'b1, 1'b1);
         if (edges == 96 || edges == 97) begin
            n_checks++;
            if (sample_valid !== (edges == 97))
               $display("FAIL mid_restart edge %0d got %b want %b", edges, sample_valid, edges == 97);
            else n_pass++;
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_ones_latency();
      test_zeros();
      test_alternating();
      test_sparse_enable();
      test_overrun();
      test_back_to_back();
      test_random();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
